// File: rtl/fg_param_ctrl_pkg.sv
// Shared types and defaults for the function-generator parameter controller.
// Holds wave/FSM encodings, the configuration word layout and the step multiply.
package fg_pkg;

   localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
   localparam int unsigned DEF_FREQ_STEPS      = 10;
   localparam logic [31:0] DEF_FSTEP_WORD      = 32'd85899;

   typedef enum logic [1:0] {
      WAVE_SINE     = 2'd0,
      WAVE_SQUARE   = 2'd1,
      WAVE_TRIANGLE = 2'd2,
      WAVE_SAW      = 2'd3
   } wave_e;

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_IDLE = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   typedef struct packed {
      logic [3:0]  freq_idx;
      logic [31:0] freq_word;
      logic [1:0]  wave_sel;
   } cfg_t;

   // (idx+1)*step mod 2^32, written as idx*step + step to stay in 32 bits.
   function automatic logic [31:0] step_word(input logic [3:0] idx, input logic [31:0] step);
      return 32'(idx) * step + step;
   endfunction

endpackage

// File: rtl/fg_param_ctrl_if.sv
// Configuration handshake from the parameter controller to the DDS core / LCD overlay.
// master drives the configuration and cfg_valid; slave returns cfg_ready.
interface fg_param_ctrl_if;

   logic        cfg_valid;
   logic        cfg_ready;
   logic [3:0]  freq_idx;
   logic [31:0] freq_word;
   logic [1:0]  wave_sel;

   modport master (
      output cfg_valid,
      output freq_idx,
      output freq_word,
      output wave_sel,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid,
      input  freq_idx,
      input  freq_word,
      input  wave_sel,
      output cfg_ready
   );

endinterface

// File: rtl/fg_param_ctrl_key_debounce.sv
// Active-low key conditioner: 2-FF sync, stability counter, registered press pulse.
// Press pulse lands DEBOUNCE_CYCLES+2 edges after the raw key is first sampled low; no backpressure.
module key_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic sys_clk,
   input  logic rst_n,
   input  logic key_in,
   output logic key_stable,
   output logic press_pulse
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [1:0]    sync_q;
   logic [CW-1:0] cnt_q;
   logic          stable_prev_q;

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q        <= 2'b11;
         cnt_q         <= '0;
         key_stable    <= 1'b1;
         stable_prev_q <= 1'b1;
         press_pulse   <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], key_in};

         if (sync_q[1] == key_stable) begin
            cnt_q <= '0;
         end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            key_stable <= sync_q[1];
            cnt_q      <= '0;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end

         // Registered falling-edge detect on the debounced level; release is ignored.
         stable_prev_q <= key_stable;
         press_pulse   <= stable_prev_q & ~key_stable;
      end
   end

endmodule

// File: rtl/fg_param_ctrl.sv
// Key-driven frequency/waveform controller; a key event updates the config one cycle later.
// Config is held on cfg_valid until cfg_ready; events arriving while a config is pending are dropped.
module fg_param_ctrl
   import fg_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned FREQ_STEPS      = DEF_FREQ_STEPS,
   parameter logic [31:0] FSTEP_WORD      = DEF_FSTEP_WORD
) (
   input  logic            sys_clk,
   input  logic            rst_n,
   input  logic            freq_up_key,
   input  logic            freq_down_key,
   input  logic            wave_form_key,
   fg_param_ctrl_if.master cfg
);

   localparam logic [3:0] IDX_MAX = 4'(FREQ_STEPS - 1);

   logic       up_evt;
   logic       down_evt;
   logic       wave_evt;
   logic [2:0] stable_unused;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up_key (
      .sys_clk     (sys_clk),
      .rst_n       (rst_n),
      .key_in      (freq_up_key),
      .key_stable  (stable_unused[0]),
      .press_pulse (up_evt)
   );

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down_key (
      .sys_clk     (sys_clk),
      .rst_n       (rst_n),
      .key_in      (freq_down_key),
      .key_stable  (stable_unused[1]),
      .press_pulse (down_evt)
   );

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_wave_key (
      .sys_clk     (sys_clk),
      .rst_n       (rst_n),
      .key_in      (wave_form_key),
      .key_stable  (stable_unused[2]),
      .press_pulse (wave_evt)
   );

   state_e state_q;
   state_e state_d;
   logic   armed_q;
   logic   load;
   cfg_t   cfg_q;
   cfg_t   cfg_d;

   // INIT waits one cycle after reset release so the first config appears on the 2nd edge.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_INIT;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         armed_q <= 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      unique case (state_q)
         ST_INIT: begin
            if (armed_q) state_d = ST_HOLD;
         end
         ST_IDLE: begin
            if (wave_evt || up_evt || down_evt) begin
               state_d = ST_HOLD;
               load    = 1'b1;
            end
         end
         ST_HOLD: begin
            if (cfg.cfg_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_INIT;
      endcase
   end

   // Priority wave > up > down; saturated steps still reload so the LCD redraws.
   always_comb begin
      cfg_d = cfg_q;
      if (wave_evt) begin
         cfg_d.wave_sel = cfg_q.wave_sel + 2'd1;
      end else if (up_evt) begin
         if (cfg_q.freq_idx < IDX_MAX) cfg_d.freq_idx = cfg_q.freq_idx + 4'd1;
      end else if (down_evt) begin
         if (cfg_q.freq_idx != 4'd0) cfg_d.freq_idx = cfg_q.freq_idx - 4'd1;
      end
      cfg_d.freq_word = step_word(cfg_d.freq_idx, FSTEP_WORD);
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_q.freq_idx  <= 4'd0;
         cfg_q.freq_word <= FSTEP_WORD;
         cfg_q.wave_sel  <= WAVE_SINE;
      end else if (load) begin
         cfg_q <= cfg_d;
      end
   end

   assign cfg.cfg_valid = (state_q == ST_HOLD);
   assign cfg.freq_idx  = cfg_q.freq_idx;
   assign cfg.freq_word = cfg_q.freq_word;
   assign cfg.wave_sel  = cfg_q.wave_sel;

endmodule

// File: tb/tb_fg_param_ctrl.sv
// Randomised and directed bench for fg_param_ctrl against a cycle-level behavioural model.
module tb_fg_param_ctrl;

   localparam int          DEB   = 4;
   localparam int          STEPS = 10;
   localparam logic [31:0] FSTEP = 32'd85899;

   logic       clk;
   logic       rst_n;
   logic [2:0] keys;  // [0] up, [1] down, [2] wave; active low

   fg_param_ctrl_if cfg_if ();

   fg_param_ctrl #(
      .DEBOUNCE_CYCLES (DEB),
      .FREQ_STEPS      (STEPS),
      .FSTEP_WORD      (FSTEP)
   ) dut (
      .sys_clk       (clk),
      .rst_n         (rst_n),
      .freq_up_key   (keys[0]),
      .freq_down_key (keys[1]),
      .wave_form_key (keys[2]),
      .cfg           (cfg_if.master)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int pulses      = 0;
   int last_rise   = -1;

   // Behavioural model: per key, how long the synchronised level has disagreed with
   // the accepted level; a press becomes an action two edges after acceptance.
   logic [2:0] m_d1 = '1, m_d2 = '1, m_stab = '1, m_fell1 = '0, m_fell2 = '0;
   logic [2:0] m_ev;
   logic       m_s;
   int         m_run [3] = '{0, 0, 0};
   int         m_since = 0;
   logic       m_valid = 1'b0;
   int         m_idx = 0;
   int         m_wave = 0;

   function automatic logic [31:0] exp_word(input int i);
      logic [63:0] p;
      p = 64'(i + 1) * 64'(FSTEP);
      return p[31:0];
   endfunction

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (!rst_n) begin
         m_d1 = '1; m_d2 = '1; m_stab = '1; m_fell1 = '0; m_fell2 = '0;
         m_run = '{0, 0, 0};
         m_since = 0; m_valid = 1'b0; m_idx = 0; m_wave = 0;
      end else begin
         m_ev = m_fell2;
         if (m_since < 2) begin
            m_since = m_since + 1;
            if (m_since == 2) m_valid = 1'b1;
         end else if (m_valid) begin
            if (cfg_if.cfg_ready) m_valid = 1'b0;
         end else if (m_ev != 3'b000) begin
            if (m_ev[2])      m_wave = (m_wave + 1) % 4;
            else if (m_ev[0]) m_idx = (m_idx < STEPS - 1) ? m_idx + 1 : m_idx;
            else              m_idx = (m_idx > 0) ? m_idx - 1 : 0;
            m_valid = 1'b1;
         end
         m_fell2 = m_fell1;
         m_fell1 = '0;
         for (int k = 0; k < 3; k++) begin
            m_s = m_d2[k];
            m_d2[k] = m_d1[k];
            m_d1[k] = keys[k];
            if (m_s != m_stab[k]) begin
               m_run[k] = m_run[k] + 1;
               if (m_run[k] == DEB) begin
                  m_stab[k]  = m_s;
                  m_run[k]   = 0;
                  m_fell1[k] = !m_s;
               end
            end else begin
               m_run[k] = 0;
            end
         end
      end
   end

   logic prev_v = 1'b0;
   always @(posedge clk) begin
      #2;
      vectors = vectors + 1;
      if (cfg_if.cfg_valid !== m_valid || cfg_if.freq_idx !== 4'(m_idx) ||
          cfg_if.wave_sel !== 2'(m_wave) || cfg_if.freq_word !== exp_word(m_idx)) begin
         miscompares = miscompares + 1;
         $display("FAIL model cyc %0d: valid %0b/%0b idx %0d/%0d wave %0d/%0d word %0d/%0d (got/expected)",
                  cyc, cfg_if.cfg_valid, m_valid, cfg_if.freq_idx, m_idx,
                  cfg_if.wave_sel, m_wave, cfg_if.freq_word, exp_word(m_idx));
      end
      if (cfg_if.cfg_valid === 1'b1 && prev_v === 1'b0) begin
         pulses    = pulses + 1;
         last_rise = cyc;
      end
      prev_v = cfg_if.cfg_valid;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors = vectors + 1;
      if (act !== exp) begin
         miscompares = miscompares + 1;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input logic [2:0] mask, input int low_n, input int high_n);
      keys = ~mask;
      tick(low_n);
      keys = 3'b111;
      tick(high_n);
   endtask

   task automatic chk_reset_vals(input string nm);
      chk({nm, "_valid"}, 32'(cfg_if.cfg_valid), 32'd0);
      chk({nm, "_idx"},   32'(cfg_if.freq_idx),  32'd0);
      chk({nm, "_wave"},  32'(cfg_if.wave_sel),  32'd0);
      chk({nm, "_word"},  cfg_if.freq_word,      32'd85899);
   endtask

   int p0;
   int k_edge;
   int wexp [5] = '{1, 2, 3, 0, 1};

   initial begin
      rst_n = 1'b0;
      keys  = 3'b111;
      cfg_if.cfg_ready = 1'b1;
      tick(3);
      chk_reset_vals("reset");

      // Initial configuration: one valid cycle, visible after the 2nd edge.
      rst_n = 1'b1;
      tick(1);
      chk("init_edge1_valid", 32'(cfg_if.cfg_valid), 32'd0);
      tick(1);
      chk("init_edge2_valid", 32'(cfg_if.cfg_valid), 32'd1);
      chk("init_word", cfg_if.freq_word, 32'd85899);
      tick(1);
      chk("init_edge3_valid", 32'(cfg_if.cfg_valid), 32'd0);
      tick(4);

      // Up saturates at 9, every press still re-presents a config.
      p0 = pulses;
      for (int i = 0; i < 12; i++) press(3'b001, 20, 20);
      chk("up_idx", 32'(cfg_if.freq_idx), 32'd9);
      chk("up_word", cfg_if.freq_word, 32'd858990);
      chk("up_pulses", 32'(pulses - p0), 32'd12);

      // Down to 0, then one saturated press.
      for (int i = 0; i < 9; i++) press(3'b010, 20, 20);
      chk("down_idx", 32'(cfg_if.freq_idx), 32'd0);
      p0 = pulses;
      press(3'b010, 20, 20);
      chk("down_sat_idx", 32'(cfg_if.freq_idx), 32'd0);
      chk("down_sat_pulses", 32'(pulses - p0), 32'd1);

      for (int i = 0; i < 5; i++) begin
         press(3'b100, 20, 20);
         chk($sformatf("wave_seq%0d", i), 32'(cfg_if.wave_sel), 32'(wexp[i]));
      end

      // Bounce never stays low long enough; the final 10-cycle low produces one event.
      p0 = pulses;
      for (int i = 0; i < 10; i++) begin
         keys[0] = 1'b0; tick(2);
         keys[0] = 1'b1; tick(1);
      end
      chk("bounce_no_event", 32'(pulses - p0), 32'd0);
      keys[0] = 1'b0;
      k_edge = cyc + 1;
      tick(10);
      keys[0] = 1'b1;
      tick(20);
      chk("bounce_one_event", 32'(pulses - p0), 32'd1);
      chk("bounce_latency", 32'(last_rise - k_edge), 32'(DEB + 3));
      chk("bounce_idx", 32'(cfg_if.freq_idx), 32'd1);

      // Simultaneous wave + up: wave wins, idx unchanged.
      p0 = pulses;
      press(3'b101, 20, 20);
      chk("simul_wave", 32'(cfg_if.wave_sel), 32'd2);
      chk("simul_idx", 32'(cfg_if.freq_idx), 32'd1);
      chk("simul_pulses", 32'(pulses - p0), 32'd1);

      // Pending config blocks a second press; reset mid-hold and mid-debounce.
      cfg_if.cfg_ready = 1'b0;
      press(3'b001, 20, 20);
      press(3'b010, 20, 20);
      chk("hold_valid", 32'(cfg_if.cfg_valid), 32'd1);
      chk("hold_idx", 32'(cfg_if.freq_idx), 32'd2);
      chk("hold_word", cfg_if.freq_word, 32'd257697);
      keys[0] = 1'b0;
      tick(3);
      rst_n = 1'b0;
      keys = 3'b111;
      tick(1);
      chk_reset_vals("midhold_reset");
      tick(2);
      rst_n = 1'b1;
      tick(1);
      chk("reinit_edge1_valid", 32'(cfg_if.cfg_valid), 32'd0);
      tick(6);
      chk("reinit_held_valid", 32'(cfg_if.cfg_valid), 32'd1);
      chk("reinit_idx", 32'(cfg_if.freq_idx), 32'd0);
      cfg_if.cfg_ready = 1'b1;
      tick(2);
      chk("reinit_done_valid", 32'(cfg_if.cfg_valid), 32'd0);

      // Random keys and ready; the compare process checks every cycle.
      for (int i = 0; i < 200; i++) begin
         cfg_if.cfg_ready = ($urandom_range(0, 9) < 7);
         keys = ($urandom_range(0, 3) == 0) ? 3'($urandom) : ~(3'b001 << $urandom_range(0, 2));
         repeat ($urandom_range(1, 12)) begin
            tick(1);
            cfg_if.cfg_ready = ($urandom_range(0, 9) < 7);
         end
         keys = 3'b111;
         tick($urandom_range(1, 8));
      end
      cfg_if.cfg_ready = 1'b1;
      tick(20);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fg_param_ctrl.md
# fg_param_ctrl

Key-driven parameter controller for the function generator. It debounces the three user keys and maintains the current frequency step and waveform selection. It presents each new setting to the DDS core and the LCD overlay through a valid/ready configuration handshake. It sits in `function_generator_top` between the key pins and the waveform datapath.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a key level (20 ms at 50 MHz).
- `FREQ_STEPS`, default 10: number of frequency steps, range 2..16.
- `FSTEP_WORD`, default 32'd85899: phase increment per step (1 kHz at 50 MHz, 32-bit accumulator).
- `sys_clk` in 1: single clock for the whole block.
- `rst_n` in 1: asynchronous, active-low reset.
- `freq_up_key` in 1: raw key input, active-low (pressed = 0), asynchronous.
- `freq_down_key` in 1: raw key input, active-low, asynchronous.
- `wave_form_key` in 1: raw key input, active-low, asynchronous.
- `cfg_ready` in 1: the downstream consumer accepts the current configuration.
- `cfg_valid` out 1: a configuration is pending.
- `freq_idx` out 4: current frequency step, 0..FREQ_STEPS-1.
- `freq_word` out 32: DDS phase increment, equal to (freq_idx+1)*FSTEP_WORD mod 2^32.
- `wave_sel` out 2: 0 sine, 1 square, 2 triangle, 3 sawtooth.

## Operation
- Each key passes through a 2-FF synchronizer, reset value 1, then a debounce counter.
  - The counter clears whenever the synchronized level equals the stable level.
  - Otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1, the stable level takes the synchronized level and the counter clears.
  - The stable level resets to 1.
- A press event is a one-cycle pulse, registered, on a stable 1→0 transition. Release produces no event.
- FSM states:
  - INIT: reset state. Next cycle goes to HOLD.
  - IDLE: `cfg_valid` = 0. On an event, update the parameters and go to HOLD.
  - HOLD: `cfg_valid` = 1. On `cfg_ready` = 1, go to IDLE.
- Event priority in IDLE when several events arrive in the same cycle: wave > up > down. Lower-priority events are discarded.
- Events arriving in INIT or HOLD are discarded, not queued.
- Wave event: `wave_sel` increments and wraps 3→0. `freq_idx` is unchanged.
- Up event: `freq_idx` increments and saturates at FREQ_STEPS-1.
- Down event: `freq_idx` decrements and saturates at 0.
- A saturated up or down event still enters HOLD and re-presents the unchanged configuration, so the LCD redraws.
- `freq_word` is a register updated on the same edge as `freq_idx`, never combinational from it. The multiply is 4×32 bits, truncated to 32 bits.
- Reset values:
  - `freq_idx` = 0, `wave_sel` = 0, `freq_word` = FSTEP_WORD.
  - `cfg_valid` = 0, FSM = INIT, all debounce counters = 0.
- Reset asserted mid-HOLD or mid-debounce returns everything to the reset values immediately. No handshake completes.

## Timing
- `cfg_valid` rises on the first clock edge after INIT, i.e. the 2nd edge after `rst_n` deasserts. This delivers the initial configuration once.
- Key to event latency, with the raw key held low from edge K:
  - The synchronized level is low at K+2.
  - The stable level falls at K+2+DEBOUNCE_CYCLES-1.
  - The event pulse occurs one cycle later.
- Event at cycle E in IDLE: the new `freq_idx`, `wave_sel`, `freq_word` and `cfg_valid` = 1 all appear at E+1, together.
- While `cfg_valid` = 1, the outputs are held stable.
- The handshake completes on the edge where `cfg_valid` & `cfg_ready` are both 1. `cfg_valid` is low the next cycle.
- `cfg_ready` may be held high permanently. `cfg_valid` is then high for exactly one cycle per configuration.
- `cfg_ready` is ignored outside HOLD.
- Minimum spacing between accepted configurations is 2 cycles (HOLD then IDLE).

## Structure
- Package `fg_pkg`:
  - Wave encodings WAVE_SINE/SQUARE/TRIANGLE/SAW.
  - FSM state encodings ST_INIT/ST_IDLE/ST_HOLD.
  - Default constants for DEBOUNCE_CYCLES, FREQ_STEPS and FSTEP_WORD.
- Sub-module `key_debounce` (parameter DEBOUNCE_CYCLES):
  - Ports: sys_clk, rst_n, key_in, key_stable, press_pulse.
  - Contains the synchronizer, the counter and edge detection.
  - Instantiated three times.
- Top level: FSM, priority logic and parameter registers.

## Test plan
- Reset release, `cfg_ready` = 1, DEBOUNCE_CYCLES = 4 → `cfg_valid` high for one cycle at the 2nd edge; `freq_idx` = 0, `wave_sel` = 0, `freq_word` = 85899.
- `freq_up_key` low 20 cycles, repeated 12 times → `freq_idx` goes 1..9 then stays 9; `freq_word` = 858990 at idx 9; 12 `cfg_valid` pulses.
- `freq_down_key` pressed at idx 0 → `freq_idx` stays 0 and one `cfg_valid` pulse occurs. `wave_form_key` pressed 5 times → `wave_sel` sequence 1, 2, 3, 0, 1.
- Key bounce of 2-cycle lows separated by 1-cycle highs for 30 cycles, DEBOUNCE_CYCLES = 4 → no event. A final low held for 10 cycles → exactly one event, at the computed latency.
- `wave_form_key` and `freq_up_key` stable edges in the same cycle → `wave_sel` increments, `freq_idx` is unchanged, one `cfg_valid` pulse.
- `cfg_ready` = 0 while in HOLD, a second key pressed, `rst_n` pulsed low mid-HOLD → the second press is dropped and the outputs hold. After reset, the outputs return to the reset values and the INIT configuration is re-emitted.
